req_encoder_rr: RTL

- Parametrised, registered successor to the team's 4:2 one-hot encoder.
- Captures single-cycle request events on N lines into a pending register. Presents them one at a time as a binary index over a valid/ready handshake.
- Two selection modes: fixed priority (lowest index wins) and round-robin.
- Sits between event sources (interrupt/status lines) and a consumer that services one index per transfer.

---
 rtl/req_encoder_rr.sv | 109 ++++++++++
 1 files changed

// File: rtl/req_encoder_rr.sv
// Registered N-line request encoder: latches event pulses into a pending set and
// hands them out one index at a time over valid/ready, fixed-priority or round-robin.
module req_encoder_rr #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic         mode,
   input  logic         out_ready,
   input  logic         ovf_clr,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pend,
   output logic [W:0]   pend_cnt,
   output logic         ovf
);

   logic         hs;
   logic [N-1:0] clr;
   logic [N-1:0] cand;
   logic [W-1:0] ptr;
   logic [W-1:0] sel_fixed;
   logic [W-1:0] sel_rr;
   logic [W-1:0] sel;
   logic         rr_found;
   logic         ovf_set;
   logic [W:0]   cnt;

   assign hs = out_valid & out_ready;

   // Bit of the index being consumed this cycle; candidates exclude it so it is
   // never presented twice.
   always_comb begin
      clr = '0;
      for (int i = 0; i < N; i++) begin
         if (hs && (out_idx == W'(i))) clr[i] = 1'b1;
      end
   end

   assign cand = pend & ~clr;

   always_comb begin
      sel_fixed = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i]) sel_fixed = W'(i);
      end
   end

   // Scan upward from the pointer, wrapping past N-1 back to 0.
   always_comb begin
      int j;
      j        = 0;
      sel_rr   = '0;
      rr_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!rr_found && cand[j]) begin
            sel_rr   = W'(j);
            rr_found = 1'b1;
         end
      end
   end

   assign sel     = mode ? sel_rr : sel_fixed;
   assign ovf_set = |(req_in & cand);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + (W+1)'(pend[i]);
      end
   end

   assign pend_cnt = cnt;

   // A new arrival on a bit that is being consumed this cycle stays pending and
   // is not an overflow; a held output is never replaced before its handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         ptr       <= '0;
         ovf       <= 1'b0;
      end else begin
         pend <= cand | req_in;
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
         if (hs) begin
            ptr <= (out_idx == W'(N - 1)) ? '0 : out_idx + 1'b1;
         end
         if (!out_valid || hs) begin
            if (|cand) begin
               out_valid <= 1'b1;
               out_idx   <= sel;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
